// File: rtl/dsp_pkg.sv
// Shared DSP definitions for the preamble-detection / autocorrelation path:
// the default complex sample type, sign-extension helper and the width
// convention used for accumulators that sum a power-of-two number of samples.
package dsp_pkg;

  // Default component width of a complex sample on this datapath.
  localparam int SAMPLE_WIDTH = 16;

  // Widest value the sign-extension helper handles.
  localparam int SEXT_MAX = 64;

  // Complex sample packed as {imag, real}, two's complement.
  typedef struct packed {
    logic signed [SAMPLE_WIDTH-1:0] im;
    logic signed [SAMPLE_WIDTH-1:0] re;
  } sample_t;

  // Width needed to hold the exact sum of 'len' values of 'w' bits each.
  function automatic int sum_width(input int w, input int len);
    return w + $clog2(len);
  endfunction

  // Sign-extend the low 'w' bits of 'v' to the full SEXT_MAX width.
  function automatic logic [SEXT_MAX-1:0] sext(input logic [SEXT_MAX-1:0] v,
                                               input int w);
    logic signed [SEXT_MAX-1:0] t;
    t = $signed(v << (SEXT_MAX - w));
    return t >>> (SEXT_MAX - w);
  endfunction

endpackage

// File: rtl/ring_buffer.sv
// History ring for complex_moving_sum: LENGTH entries of DATA_W bits held in
// registers, read asynchronously at the write pointer, written and advanced
// on wr_en. Reset clears every entry so history before reset reads as zero.
module ring_buffer #(
  parameter  int DATA_W = 32,
  parameter  int LENGTH = 16,
  localparam int PTR_W  = $clog2(LENGTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [LENGTH];
  logic [PTR_W-1:0]  wptr;

  // The oldest entry is the one about to be overwritten.
  assign rd_data = mem[wptr];

  // Store the accepted sample over the oldest entry and advance the pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: this storage must reset to zero so the window starts from empty
      // history; that requirement is why it is built from flops, not a RAM.
      for (int i = 0; i < LENGTH; i++) begin
        mem[i] <= '0;
      end
      wptr <= '0;
    end else if (wr_en) begin
      // NOTE: non-blocking assignments keep the read of mem[wptr] above and
      // the pointer update consistent with the pre-edge values.
      mem[wptr] <= wr_data;
      wptr      <= (wptr == PTR_W'(LENGTH - 1)) ? '0 : wptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/complex_moving_sum.sv
// Streaming sliding-window sum of complex samples over LENGTH samples, updated
// recursively as S[n] = S[n-1] + x[n] - x[n-LENGTH] with modulo-2^OUT_WIDTH
// arithmetic (exact, since the true window sum always fits OUT_WIDTH).
// Valid/ready on both sides; one registered output stage, no skid buffer.
// reset_n asserts asynchronously and is expected to be released synchronously
// to clk by the reset generator.
// Optional build macro COMPLEX_MOVING_SUM_WARMUP_EN: suppress outputs until the
// first full window has been accepted after reset.
module complex_moving_sum
  import dsp_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int LENGTH    = 16,
  localparam int OUT_WIDTH = sum_width(WIDTH, LENGTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [2*WIDTH-1:0]     s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [2*OUT_WIDTH-1:0] m_data
);

  // Accumulator pair, packed {imag, real} to match the output bus layout.
  typedef struct packed {
    logic signed [OUT_WIDTH-1:0] im;
    logic signed [OUT_WIDTH-1:0] re;
  } acc_t;

  acc_t               acc_q;
  acc_t               acc_d;
  logic [2*WIDTH-1:0] old_data;
  logic               accept;
  logic               emit;

  // Sign-extend one WIDTH-bit component to the accumulator width.
  function automatic logic signed [OUT_WIDTH-1:0] ext(input logic [WIDTH-1:0] c);
    return OUT_WIDTH'(sext(SEXT_MAX'(c), WIDTH));
  endfunction

  // Accept whenever the output register is empty or is being drained now.
  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

  ring_buffer #(
    .DATA_W (2 * WIDTH),
    .LENGTH (LENGTH)
  ) u_ring (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (accept),
    .wr_data (s_data),
    .rd_data (old_data)
  );

  // Next window sum: add the incoming sample, drop the one leaving the window.
  always_comb begin
    // NOTE: every always_comb output gets a full assignment on every path so
    // no latch can be inferred.
    acc_d    = acc_q;
    acc_d.re = acc_q.re + ext(s_data[WIDTH-1:0])       - ext(old_data[WIDTH-1:0]);
    acc_d.im = acc_q.im + ext(s_data[2*WIDTH-1:WIDTH]) - ext(old_data[2*WIDTH-1:WIDTH]);
  end

`ifdef COMPLEX_MOVING_SUM_WARMUP_EN
  localparam int FILL_W = $clog2(LENGTH) + 1;

  logic [FILL_W-1:0] fill_cnt;

  // Count accepts since reset, saturating once the window is full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_cnt <= '0;
    end else if (accept && (fill_cnt != FILL_W'(LENGTH))) begin
      fill_cnt <= fill_cnt + FILL_W'(1);
    end
  end

  // The LENGTH-th accept after reset is the first full window.
  assign emit = (fill_cnt >= FILL_W'(LENGTH - 1));
`else
  // Every accept produces a sum; missing history counts as zero.
  assign emit = 1'b1;
`endif

  // Accumulator and output register: load on accept, clear valid on drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else if (accept) begin
      acc_q   <= acc_d;
      m_data  <= acc_d;
      m_valid <= emit;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_complex_moving_sum.sv
// Self-checking bench for complex_moving_sum with WIDTH=16, LENGTH=4.
// Expected sums come from a vector table and from a direct window-sum model;
// they are queued when a sample is accepted and compared as outputs drain.
module tb_complex_moving_sum;
  import dsp_pkg::*;

  localparam int WIDTH  = 16;
  localparam int LENGTH = 4;
  localparam int OW     = WIDTH + $clog2(LENGTH);

`ifdef COMPLEX_MOVING_SUM_WARMUP_EN
  localparam bit WARM = 1'b1;
`else
  localparam bit WARM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              s_valid;
  logic              s_ready;
  logic [2*WIDTH-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [2*OW-1:0]   m_data;

  complex_moving_sum #(
    .WIDTH  (WIDTH),
    .LENGTH (LENGTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
  } cpx_t;

  typedef struct {
    int re;
    int im;
    int exp_re;
    int exp_im;
    bit out_wu;   // output expected when the warm-up build is used
  } vec_t;

  cpx_t exp_q[$];
  int   hist_re[LENGTH];
  int   hist_im[LENGTH];
  int   hist_ptr;
  int   tb_fill;
  int   n_checks;
  int   n_fail;
  int   n_out;
  int   n_pushed;
  int   last_re;
  int   last_im;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*WIDTH-1:0] pack(input int re, input int im);
    sample_t p;
    p.re = 16'(re);
    p.im = 16'(im);
    return p;
  endfunction

  function automatic int out_re(input logic [2*OW-1:0] d);
    logic signed [OW-1:0] r;
    r = d[OW-1:0];
    return int'(r);
  endfunction

  function automatic int out_im(input logic [2*OW-1:0] d);
    logic signed [OW-1:0] r;
    r = d[2*OW-1:OW];
    return int'(r);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LENGTH; i++) begin
      hist_re[i] = 0;
      hist_im[i] = 0;
    end
    hist_ptr = 0;
    tb_fill  = 0;
  endtask

  task automatic flush_queue();
    n_pushed -= exp_q.size();
    exp_q.delete();
  endtask

  // Present one sample, wait (bounded) for acceptance, queue its expected sum.
  task automatic send_exp(input int re, input int im, input int er, input int ei,
                          input bit push);
    int waited;
    cpx_t e;
    waited  = 0;
    s_valid = 1'b1;
    s_data  = pack(re, im);
    @(negedge clk);
    while (!s_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!s_ready) check("accept_timeout", int'(s_ready), 1);
    if (push) begin
      e.re = er;
      e.im = ei;
      exp_q.push_back(e);
      n_pushed++;
    end
    @(posedge clk);
    #1;
  endtask

  // Send with the expected value taken from a direct sum over the last LENGTH samples.
  task automatic model_send(input int re, input int im);
    int sr;
    int si;
    bit produce;
    hist_re[hist_ptr] = re;
    hist_im[hist_ptr] = im;
    hist_ptr = (hist_ptr + 1) % LENGTH;
    sr = 0;
    si = 0;
    for (int i = 0; i < LENGTH; i++) begin
      sr += hist_re[i];
      si += hist_im[i];
    end
    produce = WARM ? (tb_fill >= LENGTH - 1) : 1'b1;
    if (tb_fill < LENGTH) tb_fill++;
    send_exp(re, im, sr, si, produce);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    flush_queue();
    model_clear();
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Scoreboard: each output handshake pops and compares one expected sum.
  always @(negedge clk) begin
    if (reset_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", out_re(m_data), 32'h7fffffff);
      end else begin
        cpx_t e;
        e = exp_q.pop_front();
        check("out_re", out_re(m_data), e.re);
        check("out_im", out_im(m_data), e.im);
        last_re = out_re(m_data);
        last_im = out_im(m_data);
        n_out++;
      end
    end
  end

  initial begin
    vec_t vecs[6];
    int   stall_idx;
    int   out_before;

    n_checks = 0;
    n_fail   = 0;
    n_out    = 0;
    n_pushed = 0;
    model_clear();

    vecs[0] = '{re: 1, im: 0, exp_re: 1,  exp_im: 0, out_wu: 1'b0};
    vecs[1] = '{re: 2, im: 0, exp_re: 3,  exp_im: 0, out_wu: 1'b0};
    vecs[2] = '{re: 3, im: 0, exp_re: 6,  exp_im: 0, out_wu: 1'b0};
    vecs[3] = '{re: 4, im: 0, exp_re: 10, exp_im: 0, out_wu: 1'b1};
    vecs[4] = '{re: 5, im: 0, exp_re: 14, exp_im: 0, out_wu: 1'b1};
    vecs[5] = '{re: 6, im: 0, exp_re: 18, exp_im: 0, out_wu: 1'b1};

    // Reset state.
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    @(negedge clk);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data",  int'(m_data != '0), 0);
    check("rst_s_ready", int'(s_ready), 1);
    do_reset();

    // Ramp 1..6 back to back with m_ready high.
    out_before = n_out;
    for (int i = 0; i < 6; i++) begin
      send_exp(vecs[i].re, vecs[i].im, vecs[i].exp_re, vecs[i].exp_im,
               WARM ? vecs[i].out_wu : 1'b1);
    end
    s_valid = 1'b0;
    wait_drain();
    check("ramp_out_count", n_out - out_before, WARM ? 3 : 6);

    // Same ramp with a 3-cycle downstream stall after an output is presented.
    do_reset();
    stall_idx  = WARM ? 4 : 1;
    out_before = n_out;
    for (int i = 0; i < 6; i++) begin
      send_exp(vecs[i].re, vecs[i].im, vecs[i].exp_re, vecs[i].exp_im,
               WARM ? vecs[i].out_wu : 1'b1);
      if (i == stall_idx) begin
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = pack(999, -999);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_m_valid", int'(m_valid), 1);
          check("stall_m_data", out_re(m_data), vecs[i].exp_re);
          check("stall_s_ready", int'(s_ready), 0);
          @(posedge clk);
          #1;
          s_data = pack(k * 7 + 5, 3);
        end
        m_ready = 1'b1;
      end
    end
    s_valid = 1'b0;
    wait_drain();
    check("stall_out_count", n_out - out_before, WARM ? 3 : 6);

    // Most negative inputs, then most positive inputs.
    do_reset();
    for (int i = 0; i < 8; i++) model_send(-32768, -32768);
    s_valid = 1'b0;
    wait_drain();
    check("neg_final_re", last_re, -131072);
    check("neg_final_im", last_im, -131072);
    for (int i = 0; i < 8; i++) model_send(32767, 32767);
    s_valid = 1'b0;
    wait_drain();
    check("pos_final_re", last_re, 131068);
    check("pos_final_im", last_im, 131068);

    // Alternating +/-100 across three pointer wraps, imag mirrored.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      model_send((i % 2 == 0) ? 100 : -100, (i % 2 == 0) ? -100 : 100);
    end
    s_valid = 1'b0;
    wait_drain();
    check("alt_final_re", last_re, 0);
    check("alt_final_im", last_im, 0);

    // Asynchronous reset pulse between edges while an output is pending.
    do_reset();
    for (int v = 1; v <= 5; v++) model_send(v, -v);
    s_valid = 1'b0;
    #1;
    check("pre_reset_valid", int'(m_valid), 1);
    reset_n = 1'b0;
    #1;
    check("async_reset_valid", int'(m_valid), 0);
    #1;
    reset_n = 1'b1;
    flush_queue();
    model_clear();
    model_send(7, 0);
    s_valid = 1'b0;
    @(negedge clk);
    if (WARM) begin
      check("post_reset_warm_valid", int'(m_valid), 0);
    end else begin
      check("post_reset_valid", int'(m_valid), 1);
      check("post_reset_data", out_re(m_data), 7);
    end
    for (int i = 0; i < 3; i++) model_send(0, 0);
    s_valid = 1'b0;
    wait_drain();
    check("post_reset_last", last_re, 7);

    check("total_outputs", n_out, n_pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
